// File: rtl/btb_branch_predictor_pkg.sv
// Shared definitions for the BTB branch predictor: counter encodings,
// default table size, PC slice positions and the statistics limit.
package btb_branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam int          DEFAULT_ENTRIES = 64;
    localparam int          IDX_LO          = 2;
    localparam logic [31:0] CNT_SAT         = 32'hFFFF_FFFF;

    function automatic int idx_hi(input int idx_w);
        return idx_w + IDX_LO - 1;
    endfunction

    function automatic int tag_lo(input int idx_w);
        return idx_w + IDX_LO;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a 2-bit saturating branch counter.
module bp_sat_counter
    import btb_branch_predictor_pkg::*;
(
    input  ctr_e cur,
    input  logic taken,
    output ctr_e next
);

    // NOTE: assign a default before the case so no path leaves next unassigned (no latch).
    always_comb begin
        next = cur;
        case (cur)
            SNT: next = taken ? WNT : SNT;
            WNT: next = taken ? WT  : SNT;
            WT:  next = taken ? ST  : WNT;
            ST:  next = taken ? ST  : WT;
            default: next = WNT;
        endcase
    end

endmodule

// File: rtl/btb_branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational IF prediction,
// EX mispredict detection, EX-time training and branch statistics.
module btb_branch_predictor
    import btb_branch_predictor_pkg::*;
#(
    parameter int ENTRIES = DEFAULT_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        BranchValidE,
    input  logic [31:0] PCE,
    input  logic        BrTakenE,
    input  logic [31:0] BranchTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredE,
    output logic [31:0] CorrectPCE,
    output logic [31:0] BranchCnt,
    output logic [31:0] MispredCnt
);

    localparam int IDX_HI = idx_hi(IDX_W);
    localparam int TAG_LO = tag_lo(IDX_W);
    localparam int TAG_W  = 32 - TAG_LO;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    ctr_e              ctr_q    [ENTRIES];

    logic [IDX_W-1:0]  idx_f, idx_e;
    logic [TAG_W-1:0]  tag_f, tag_e;
    logic              hit_f, hit_e;
    ctr_e              ctr_next;
    logic              unused_pc_bits;

    assign idx_f = PCF[IDX_HI:IDX_LO];
    assign tag_f = PCF[31:TAG_LO];
    assign idx_e = PCE[IDX_HI:IDX_LO];
    assign tag_e = PCE[31:TAG_LO];

    // Instruction alignment bits play no part in lookup.
    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

    assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign PredTakenF  = hit_f && ctr_q[idx_f][1];
    assign PredTargetF = PredTakenF ? target_q[idx_f] : PCF + 32'd4;

    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    always_comb begin
        MispredE   = 1'b0;
        CorrectPCE = PCE + 32'd4;
        if (BranchValidE) begin
            MispredE = (BrTakenE != PredTakenE) ||
                       (BrTakenE && PredTakenE && (PredTargetE != BranchTargetE));
            if (BrTakenE) begin
                CorrectPCE = BranchTargetE;
            end
        end
    end

    bp_sat_counter u_sat_counter (
        .cur   (ctr_q[idx_e]),
        .taken (BrTakenE),
        .next  (ctr_next)
    );

    // NOTE: the whole table is reset, not just valid, so the counters start at WNT;
    // this forces flops rather than block RAM.
    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else if (BranchValidE) begin
            // NOTE: non-blocking writes keep this cycle's IF read on pre-edge contents.
            if (hit_e) begin
                ctr_q[idx_e] <= ctr_next;
                if (BrTakenE) begin
                    target_q[idx_e] <= BranchTargetE;
                end
            end else if (BrTakenE) begin
                valid_q[idx_e]  <= 1'b1;
                tag_q[idx_e]    <= tag_e;
                target_q[idx_e] <= BranchTargetE;
                ctr_q[idx_e]    <= WT;
            end
        end
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            BranchCnt  <= '0;
            MispredCnt <= '0;
        end else begin
            if (BranchValidE && (BranchCnt != CNT_SAT)) begin
                BranchCnt <= BranchCnt + 32'd1;
            end
            if (MispredE && (MispredCnt != CNT_SAT)) begin
                MispredCnt <= MispredCnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_btb_branch_predictor.sv
// Randomized and directed bench for btb_branch_predictor against a
// behavioural table model of the predictor rules.
module tb_btb_branch_predictor;

    localparam int ENTRIES = 64;

    logic        CPU_CLK;
    logic        CPU_RST;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        BranchValidE;
    logic [31:0] PCE;
    logic        BrTakenE;
    logic [31:0] BranchTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredE;
    logic [31:0] CorrectPCE;
    logic [31:0] BranchCnt;
    logic [31:0] MispredCnt;

    btb_branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .CPU_CLK       (CPU_CLK),
        .CPU_RST       (CPU_RST),
        .PCF           (PCF),
        .PredTakenF    (PredTakenF),
        .PredTargetF   (PredTargetF),
        .BranchValidE  (BranchValidE),
        .PCE           (PCE),
        .BrTakenE      (BrTakenE),
        .BranchTargetE (BranchTargetE),
        .PredTakenE    (PredTakenE),
        .PredTargetE   (PredTargetE),
        .MispredE      (MispredE),
        .CorrectPCE    (CorrectPCE),
        .BranchCnt     (BranchCnt),
        .MispredCnt    (MispredCnt)
    );

    initial CPU_CLK = 1'b0;
    always #5 CPU_CLK = ~CPU_CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: one record per index, counter as an integer 0..3.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int unsigned m_bcnt;
    int unsigned m_mcnt;

    logic [31:0] pool [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_bcnt = 0;
        m_mcnt = 0;
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic taken, output logic [31:0] target);
        int i;
        bit hit;
        i      = idx_of(pc);
        hit    = m_valid[i] && (m_tag[i] == tag_of(pc));
        taken  = hit && (m_ctr[i] >= 2);
        target = taken ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic model_train(input logic [31:0] pc, input logic taken, input logic [31:0] target);
        int i;
        i = idx_of(pc);
        if (m_valid[i] && (m_tag[i] == tag_of(pc))) begin
            if (taken) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = target;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(pc);
            m_tgt[i]   = target;
            m_ctr[i]   = 2;
        end
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic cyc(input logic [31:0] pcf, input logic bv, input logic [31:0] pce,
                       input logic bt, input logic [31:0] btgt,
                       input logic pt, input logic [31:0] ptgt);
        logic        e_taken;
        logic [31:0] e_target;
        logic        e_mis;
        logic [31:0] e_cpc;
        PCF = pcf; BranchValidE = bv; PCE = pce; BrTakenE = bt;
        BranchTargetE = btgt; PredTakenE = pt; PredTargetE = ptgt;
        #2;
        model_predict(pcf, e_taken, e_target);
        e_mis = bv && ((bt != pt) || (bt && pt && (ptgt != btgt)));
        e_cpc = (bv && bt) ? btgt : pce + 32'd4;
        check("pred_taken", 32'(PredTakenF), 32'(e_taken));
        check("pred_target", PredTargetF, e_target);
        check("mispred", 32'(MispredE), 32'(e_mis));
        check("correct_pc", CorrectPCE, e_cpc);
        @(posedge CPU_CLK);
        if (bv) begin
            model_train(pce, bt, btgt);
            m_bcnt++;
        end
        if (e_mis) m_mcnt++;
        #1;
        check("branch_cnt", BranchCnt, m_bcnt);
        check("mispred_cnt", MispredCnt, m_mcnt);
        BranchValidE = 1'b0;
    endtask

    // EX resolution whose carried prediction is what the model predicted in IF.
    task automatic resolve(input logic [31:0] pc, input logic bt, input logic [31:0] btgt);
        logic        pt;
        logic [31:0] ptgt;
        model_predict(pc, pt, ptgt);
        cyc(pc, 1'b1, pc, bt, btgt, pt, ptgt);
    endtask

    task automatic peek(input string tag, input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_tgt);
        PCF = pc;
        #1;
        check({tag, "_taken"}, 32'(PredTakenF), 32'(exp_t));
        check({tag, "_target"}, PredTargetF, exp_tgt);
    endtask

    initial begin
        CPU_RST = 1'b1; PCF = 32'h100; BranchValidE = 1'b0; PCE = '0; BrTakenE = 1'b0;
        BranchTargetE = '0; PredTakenE = 1'b0; PredTargetE = '0;
        model_reset();
        #12;
        check("rst_pred_taken", 32'(PredTakenF), 32'd0);
        check("rst_pred_target", PredTargetF, 32'h104);
        check("rst_bcnt", BranchCnt, 32'd0);
        check("rst_mcnt", MispredCnt, 32'd0);
        @(negedge CPU_CLK);
        CPU_RST = 1'b0;
        @(posedge CPU_CLK);
        #1;

        // Cold start allocate.
        cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        check("cold_mcnt", MispredCnt, 32'd1);
        peek("cold_hit", 32'h100, 1'b1, 32'h80);

        // Saturate up, then walk down to strongly not-taken.
        for (int i = 0; i < 3; i++) resolve(32'h100, 1'b1, 32'h80);
        resolve(32'h100, 1'b0, 32'h0);
        peek("st_to_wt", 32'h100, 1'b1, 32'h80);
        resolve(32'h100, 1'b0, 32'h0);
        peek("wt_to_wnt", 32'h100, 1'b0, 32'h104);
        for (int i = 0; i < 4; i++) resolve(32'h100, 1'b0, 32'h0);
        resolve(32'h100, 1'b1, 32'h80);
        peek("floor_then_taken", 32'h100, 1'b0, 32'h104);

        // Alias at the same index replaces the entry.
        peek("alias_miss", 32'h200, 1'b0, 32'h204);
        resolve(32'h200, 1'b1, 32'h40);
        peek("alias_hit", 32'h200, 1'b1, 32'h40);
        peek("alias_evicted", 32'h100, 1'b0, 32'h104);

        // Target change on a correctly predicted-taken branch.
        resolve(32'h100, 1'b1, 32'h80);
        peek("retrain", 32'h100, 1'b1, 32'h80);
        cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
        peek("new_target", 32'h100, 1'b1, 32'h90);

        // Same-cycle IF read and EX write at one index.
        cyc(32'h300, 1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304);
        peek("bypass_next", 32'h300, 1'b1, 32'h500);

        // Randomized traffic over a small pool with aliasing tags.
        for (int i = 0; i < 16; i++)
            pool[i] = 32'h1000 | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 8);
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pcf, pce, btgt, ptgt;
            logic        bv, bt, pt;
            pcf  = pool[$urandom_range(0, 15)];
            pce  = pool[$urandom_range(0, 15)];
            bv   = ($urandom_range(0, 3) != 0);
            bt   = $urandom_range(0, 1) == 1;
            btgt = 32'($urandom_range(0, 15)) << 4;
            model_predict(pce, pt, ptgt);
            if ($urandom_range(0, 9) < 3) begin
                pt   = $urandom_range(0, 1) == 1;
                ptgt = 32'($urandom_range(0, 15)) << 4;
            end
            cyc(pcf, bv, pce, bt, btgt, pt, ptgt);
        end

        // Asynchronous reset between edges with a populated table.
        resolve(32'h300, 1'b1, 32'h500);
        PCF = 32'h300;
        #2;
        CPU_RST = 1'b1;
        #1;
        model_reset();
        check("async_pred_taken", 32'(PredTakenF), 32'd0);
        check("async_pred_target", PredTargetF, 32'h304);
        check("async_bcnt", BranchCnt, 32'd0);
        check("async_mcnt", MispredCnt, 32'd0);
        @(posedge CPU_CLK);
        #3;
        CPU_RST = 1'b0;
        @(posedge CPU_CLK);
        #1;
        peek("post_rst_300", 32'h300, 1'b0, 32'h304);
        peek("post_rst_200", 32'h200, 1'b0, 32'h204);
        for (int i = 0; i < 16; i++) peek("post_rst_pool", pool[i], 1'b0, pool[i] + 32'd4);
        check("post_rst_bcnt", BranchCnt, 32'd0);
        check("post_rst_mcnt", MispredCnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btb_branch_predictor.md
Name: btb_branch_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating counters for the 5-stage RV32 pipeline.
- Predicts in IF: supplies the predicted-taken flag and target, which the next-PC selection uses in place of PCF+4.
- Trains in EX from the resolved branch outcome.
- Produces the EX-stage mispredict flush and the corrected PC.

Parameters:
- ENTRIES, 64, number of BTB entries; power of two, 4..1024.
- IDX_W, $clog2(ENTRIES), index width. Index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2].

Ports:
- CPU_CLK  in  1  clock; all state updates on the rising edge.
- CPU_RST  in  1  asynchronous, active-high reset.
- PCF  in  32  fetch-stage PC.
- PredTakenF  out  1  IF prediction: taken.
- PredTargetF  out  32  IF predicted next PC.
- BranchValidE  in  1  a conditional branch is in EX and is not flushed or stalled. This is the update enable.
- PCE  in  32  PC of the EX branch.
- BrTakenE  in  1  resolved branch outcome.
- BranchTargetE  in  32  resolved branch target.
- PredTakenE  in  1  PredTakenF of this instruction, carried down the pipeline.
- PredTargetE  in  32  PredTargetF of this instruction, carried down the pipeline.
- MispredE  out  1  flush IF/ID and redirect fetch.
- CorrectPCE  out  32  redirect PC.
- BranchCnt  out  32  number of resolved branches.
- MispredCnt  out  32  number of mispredictions.

Behaviour:
- Storage per entry: valid (1), tag (30-IDX_W), target (32), ctr (2). Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Reset (async, any time including mid-update): all valid=0, all ctr=01, BranchCnt=0, MispredCnt=0. Combinational outputs then follow from the cleared state: PredTakenF=0, PredTargetF=PCF+4.
- IF read is combinational, zero latency:
  - hitF = valid[idxF] & (tag[idxF]==PCF tag bits).
  - PredTakenF = hitF & ctr[idxF][1].
  - PredTargetF = PredTakenF ? target[idxF] : PCF+4 (32-bit wrap).
- EX check is combinational:
  - MispredE = BranchValidE & ((BrTakenE != PredTakenE) | (BrTakenE & PredTakenE & (PredTargetE != BranchTargetE))).
  - CorrectPCE = BrTakenE ? BranchTargetE : PCE+4.
  - When BranchValidE=0: MispredE=0 and CorrectPCE=PCE+4.
- EX update is at the rising edge when BranchValidE=1, using a second read port at idxE/tagE from PCE.
  - Hit:
    - ctr saturating: +1 if BrTakenE, capped at 11; -1 if not taken, floored at 00.
    - If BrTakenE, target <= BranchTargetE.
  - Miss and BrTakenE: allocate (replace) the entry: valid=1, tag=tagE, target=BranchTargetE, ctr=10.
  - Miss and not taken: no table change.
- Statistics:
  - BranchCnt +1 on each BranchValidE cycle.
  - MispredCnt +1 when MispredE=1.
  - Both saturate at 32'hFFFF_FFFF.
- Same-cycle IF read and EX write to the same index: IF sees pre-edge contents. The write is visible to lookups from the next cycle.
- Priority in the PC mux (outside this block): MispredE/CorrectPCE over JalrE over JalD over PredTakenF over PCF+4.
- PCs with PC[1:0]!=0 are not checked; bits [1:0] are ignored.

Decomposition:
- Shared package:
  - counter encodings SNT/WNT/WT/ST;
  - the default for ENTRIES;
  - the index/tag slice positions as functions of IDX_W;
  - the 32-bit saturation limit.
- One sub-module, bp_sat_counter: 2-bit next-state logic (cur, taken -> next). It is purely combinational and instantiated on the update path.
- The table is a register array in the top; it has asynchronous reset and cannot be mapped to BRAM.

Test Plan:
- Cold start: reset, then PCF=0x0000_0100 -> PredTakenF=0, PredTargetF=0x0000_0104. Then BranchValidE=1, PCE=0x100, BrTakenE=1, BranchTargetE=0x80, PredTakenE=0 -> MispredE=1, CorrectPCE=0x80, MispredCnt=1. Next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x80.
- Saturation:
  - Train PCE=0x100 taken 3 more times -> ctr=11.
  - One not-taken -> ctr=10, still predicts taken.
  - Second not-taken -> ctr=01, PredTakenF=0, PredTargetF=0x104.
  - Four more not-taken -> ctr stays 00.
- Alias/tag miss (ENTRIES=64): PCF=0x100+0x100=0x200 (same index, different tag) -> PredTakenF=0. Taken update at 0x200 with target 0x40 replaces the entry, so 0x100 then misses.
- Target change: entry for 0x100 predicts 0x80. Resolve taken to 0x90 with PredTakenE=1, PredTargetE=0x80 -> MispredE=1, CorrectPCE=0x90, next lookup gives 0x90.
- Bypass ordering: PCF=PCE=0x300 in the same cycle with a taken allocate -> PredTakenF=0 this cycle, 1 next cycle.
- Async reset mid-stream: assert CPU_RST between clock edges with the table populated -> outputs return to the reset values immediately. After release, PredTakenF=0 for all trained PCs and both counters read 0.
